// File: rtl/exec_unit_pkg.sv
// ============================================================================
// exec_unit_pkg : opcode map, control states and accumulator width helper
//                 shared by the exec_unit_v2 files.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

package exec_unit_pkg;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_LDA  = 8'h01;
  localparam logic [7:0] OP_LDB  = 8'h02;
  localparam logic [7:0] OP_LDO  = 8'h03;
  localparam logic [7:0] OP_LDSA = 8'h04;
  localparam logic [7:0] OP_LDSB = 8'h05;
  localparam logic [7:0] OP_LSH  = 8'h06;
  localparam logic [7:0] OP_RSH  = 8'h07;
  localparam logic [7:0] OP_ADD  = 8'h08;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_AND  = 8'h0A;
  localparam logic [7:0] OP_OR   = 8'h0B;
  localparam logic [7:0] OP_XOR  = 8'h0C;
  localparam logic [7:0] OP_INV  = 8'h0D;
  localparam logic [7:0] OP_CLR  = 8'h0E;
  localparam logic [7:0] OP_SNZA = 8'h0F;
  localparam logic [7:0] OP_SNZS = 8'h10;
  localparam logic [7:0] OP_MUL  = 8'h11;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_MUL_BUSY = 1'b1
  } state_t;

  function automatic int acc_width(input int data_w);
    return 2 * data_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_unit_v2_mul.sv
// ============================================================================
// shift_add_multiplier : unsigned DATA_W x DATA_W multiplier, one partial
//                        product per cycle; done marks the final iteration.
// Revision             : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_add_multiplier #(
  parameter int DATA_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   product,
  output logic                  done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic                 busy;
  logic [CNT_W-1:0]     cnt;
  logic [2*DATA_W-1:0]  mcand;
  logic [2*DATA_W-1:0]  prod;
  logic [DATA_W-1:0]    mplier;
  logic [2*DATA_W-1:0]  partial;

  // product is the running sum including this cycle's partial term
  assign partial = mplier[0] ? mcand : '0;
  assign product = prod + partial;
  assign done    = busy && (cnt == CNT_W'(DATA_W - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      prod   <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{DATA_W{1'b0}}, a};
      mplier <= b;
      prod   <= '0;
    end else if (busy) begin
      prod   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/exec_unit_v2.sv
// ============================================================================
// exec_unit_v2 : accumulator execution unit with shift register, skip logic
//                and optional multi-cycle multiply (EXEC_UNIT_MUL_EN).
// Revision     : 1.0  initial release
// ============================================================================
`default_nettype none

module exec_unit_v2
  import exec_unit_pkg::*;
#(
  parameter int  DATA_W = 4,
  parameter int  OPC_W  = 8,
  localparam int ACC_W  = acc_width(DATA_W)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [OPC_W-1:0]    opcode,
  input  logic [2*DATA_W-1:0] operand,
  output logic                ready,
  output logic [ACC_W-1:0]    cpu_out,
  output logic                valid_out,
  output logic                ovf,
  output logic                skip_pend
);

  localparam int OPX = (OPC_W > 8) ? OPC_W : 8;

  logic [DATA_W-1:0] a, b;
  logic [ACC_W-1:0]  s, acc, ab;
  logic              sf;
  logic [ACC_W:0]    add_r, sub_r;
  logic [OPX-1:0]    opc_x;
  logic              accept, exec;
  logic              sf_unused;

  // SF is architectural state with no reader inside this block
  assign sf_unused = sf;

  assign opc_x  = OPX'(opcode);
  assign ab     = {a, b};
  assign add_r  = {1'b0, acc} + {1'b0, ab};
  assign sub_r  = {1'b0, acc} - {1'b0, ab};
  assign accept = start && ready;
  assign exec   = accept && !skip_pend;

`ifdef EXEC_UNIT_MUL_EN
  state_t             state, next_state;
  logic               mul_start, mul_done;
  logic [ACC_W-1:0]   mul_product;

  assign mul_start = exec && (opc_x == OPX'(OP_MUL));

  shift_add_multiplier #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .product (mul_product),
    .done    (mul_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (mul_start) next_state = ST_MUL_BUSY;
      end
      ST_MUL_BUSY: if (mul_done) next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end
`else
  assign ready = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a         <= '0;
      b         <= '0;
      s         <= '0;
      sf        <= 1'b0;
      acc       <= '0;
      cpu_out   <= '0;
      ovf       <= 1'b0;
      skip_pend <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept && skip_pend) begin
        skip_pend <= 1'b0;
      end else if (exec) begin
        case (opc_x)
          OPX'(OP_LDA):  a <= operand[2*DATA_W-1:DATA_W];
          OPX'(OP_LDB):  b <= operand[DATA_W-1:0];
          OPX'(OP_LDO): begin
            cpu_out   <= acc;
            valid_out <= 1'b1;
          end
          OPX'(OP_LDSA): begin
            s  <= {{DATA_W{1'b0}}, a};
            sf <= 1'b0;
          end
          OPX'(OP_LDSB): begin
            s  <= {{DATA_W{1'b0}}, b};
            sf <= 1'b0;
          end
          OPX'(OP_LSH): begin
            s  <= s << 1;
            sf <= s[ACC_W-1];
          end
          OPX'(OP_RSH): begin
            s  <= s >> 1;
            sf <= s[0];
          end
          OPX'(OP_ADD): begin
            acc <= add_r[ACC_W-1:0];
            if (add_r[ACC_W]) ovf <= 1'b1;
          end
          OPX'(OP_SUB): begin
            acc <= sub_r[ACC_W-1:0];
            if (sub_r[ACC_W]) ovf <= 1'b1;
          end
          OPX'(OP_AND):  acc <= acc & ab;
          OPX'(OP_OR):   acc <= acc | ab;
          OPX'(OP_XOR):  acc <= acc ^ ab;
          OPX'(OP_INV):  acc <= ~acc;
          OPX'(OP_CLR): begin
            acc <= '0;
            ovf <= 1'b0;
          end
          OPX'(OP_SNZA): if (a == '0) skip_pend <= 1'b1;
          OPX'(OP_SNZS): if (s == '0) skip_pend <= 1'b1;
          default: ;
        endcase
      end
`ifdef EXEC_UNIT_MUL_EN
      if (mul_done) acc <= mul_product;
`endif
    end
  end

endmodule

`default_nettype wire
